// File: rtl/state_arbiter_pkg.sv
// Shared types and helpers for the state_arbiter block.
package state_arbiter_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  // Width of a reader index; a single reader still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/state_arbiter_if.sv
// Valid/ready data channel used for the write, read-request and read-response ports.
interface dti #(
  parameter int W = 16
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input ready);
  modport consumer (input valid, input data, output ready);
  modport master   (output valid, output data, input ready);
  modport slave    (input valid, input data, output ready);
endinterface

// File: rtl/state_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after i_start, skipping i_excl.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  input  logic [N-1:0]  i_excl,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [N-1:0] w_cand;

  assign w_cand = i_req & ~i_excl;

  always_comb begin : search
    logic [IW-1:0] c;
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    o_found = 1'b0;
    o_idx   = '0;
    c       = i_start;
    for (int k = 0; k < N; k++) begin
      if (!o_found && w_cand[c]) begin
        o_found = 1'b1;
        o_idx   = c;
      end
      c = (c == LAST) ? '0 : c + IW'(1);
    end
  end

endmodule

// File: rtl/state_arbiter.sv
// Single-writer, multi-reader shared state register with round-robin read grants.
// Writes stall while a granted read awaits its handshake, so dout data stays stable.
module state_arbiter
  import state_arbiter_pkg::*;
#(
  parameter int           W    = 16,
  parameter int           NRD  = 2,
  parameter logic [W-1:0] INIT = '0
) (
  input logic  clk,
  input logic  rst,
  dti.consumer din,
  dti.consumer rd   [0:NRD-1],
  dti.producer dout [0:NRD-1]
);
  localparam int            IW       = idx_width(NRD);
  localparam logic [IW-1:0] LAST_IDX = IW'(NRD - 1);

  arb_state_t     r_state, w_state_nxt;
  logic [IW-1:0]  r_g, w_g_nxt;
  logic [IW-1:0]  r_last, w_last_nxt;
  logic [W-1:0]   r_data;

  logic [NRD-1:0] w_req, w_dout_rdy, w_sel, w_excl, w_unused_rd_data;
  logic [IW-1:0]  w_base, w_start, w_pick;
  logic           w_found, w_granted, w_g_rdy, w_din_rdy, w_wr;

  for (genvar i = 0; i < NRD; i++) begin : g_port
    assign w_req[i]            = rd[i].valid;
    assign w_unused_rd_data[i] = rd[i].data;
    assign w_dout_rdy[i]       = dout[i].ready;
    assign w_sel[i]            = w_granted && (r_g == IW'(i));
    assign dout[i].valid       = w_sel[i];
    assign dout[i].data        = r_data;
    assign rd[i].ready         = w_sel[i] && w_dout_rdy[i];
  end

  assign w_granted = (r_state == GRANT);
  assign w_g_rdy   = w_dout_rdy[r_g];
  assign w_din_rdy = !w_granted || w_g_rdy;
  assign din.ready = w_din_rdy;
  assign w_wr      = din.valid && w_din_rdy;

  // IDLE searches from last+1; GRANT searches from g+1 with g itself excluded.
  assign w_base  = w_granted ? r_g : r_last;
  assign w_start = (w_base == LAST_IDX) ? '0 : w_base + IW'(1);
  assign w_excl  = w_granted ? (NRD'(1) << r_g) : '0;

  rr_pick #(
    .N  (NRD),
    .IW (IW)
  ) u_pick (
    .i_req   (w_req),
    .i_start (w_start),
    .i_excl  (w_excl),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_g_nxt     = r_g;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_g_nxt     = w_pick;
          w_last_nxt  = w_pick;
        end
      end
      GRANT: begin
        if (w_g_rdy) begin
          if (w_found) begin
            w_g_nxt    = w_pick;
            w_last_nxt = w_pick;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: the shared register is a single word, so it is reset to INIT along with the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_g     <= '0;
      r_last  <= LAST_IDX;
      r_data  <= INIT;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_nxt;
      r_g     <= w_g_nxt;
      r_last  <= w_last_nxt;
      if (w_wr) r_data <= din.data;
    end
  end

endmodule

// File: tb/tb_state_arbiter.sv
// Directed and randomized checks of state_arbiter (NRD=2 and NRD=3) against a behavioural model.
module tb_state_arbiter;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dti #(.W(W)) din2 ();
  dti #(.W(1)) rd2   [0:1] ();
  dti #(.W(W)) dout2 [0:1] ();
  dti #(.W(W)) din3 ();
  dti #(.W(1)) rd3   [0:2] ();
  dti #(.W(W)) dout3 [0:2] ();

  state_arbiter #(.W(W), .NRD(2), .INIT(16'd5)) u_dut2 (
    .clk (clk), .rst (rst), .din (din2), .rd (rd2), .dout (dout2)
  );

  state_arbiter #(.W(W), .NRD(3), .INIT(16'h00A0)) u_dut3 (
    .clk (clk), .rst (rst), .din (din3), .rd (rd3), .dout (dout3)
  );

  // Stimulus, index 0 = NRD=2 instance, index 1 = NRD=3 instance.
  logic [2:0]   rv   [2];
  logic [2:0]   i_dr [2];
  logic         i_dv [2];
  logic [W-1:0] i_dd [2];

  assign din2.valid = i_dv[0];      assign din2.data = i_dd[0];
  assign din3.valid = i_dv[1];      assign din3.data = i_dd[1];
  assign rd2[0].valid = rv[0][0];   assign rd2[0].data = 1'b0;
  assign rd2[1].valid = rv[0][1];   assign rd2[1].data = 1'b0;
  assign rd3[0].valid = rv[1][0];   assign rd3[0].data = 1'b0;
  assign rd3[1].valid = rv[1][1];   assign rd3[1].data = 1'b0;
  assign rd3[2].valid = rv[1][2];   assign rd3[2].data = 1'b0;
  assign dout2[0].ready = i_dr[0][0];
  assign dout2[1].ready = i_dr[0][1];
  assign dout3[0].ready = i_dr[1][0];
  assign dout3[1].ready = i_dr[1][1];
  assign dout3[2].ready = i_dr[1][2];

  wire [2:0]   o_dv  [2];
  wire [2:0]   o_rr  [2];
  wire         o_dir [2];
  wire [W-1:0] o_dd  [2][3];

  assign o_dv[0]  = {1'b0, dout2[1].valid, dout2[0].valid};
  assign o_dv[1]  = {dout3[2].valid, dout3[1].valid, dout3[0].valid};
  assign o_rr[0]  = {1'b0, rd2[1].ready, rd2[0].ready};
  assign o_rr[1]  = {rd3[2].ready, rd3[1].ready, rd3[0].ready};
  assign o_dir[0] = din2.ready;
  assign o_dir[1] = din3.ready;
  assign o_dd[0][0] = dout2[0].data;
  assign o_dd[0][1] = dout2[1].data;
  assign o_dd[0][2] = '0;
  assign o_dd[1][0] = dout3[0].data;
  assign o_dd[1][1] = dout3[1].data;
  assign o_dd[1][2] = dout3[2].data;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: a busy flag, the granted reader, the last winner and the stored word.
  bit           m_busy [2];
  int           m_g    [2];
  int           m_last [2];
  logic [W-1:0] m_data [2];
  logic [2:0]   e_dv   [2];
  logic [2:0]   e_rr   [2];
  logic         e_dir  [2];
  logic [2:0]   hs_rd  [2];
  bit           wr_acc [2];

  function automatic int nrd_of(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic logic [W-1:0] init_of(input int k);
    return (k == 0) ? 16'd5 : 16'h00A0;
  endfunction

  // First requester after 'from' in circular order, never 'excl'; -1 if none.
  function automatic int rr_next(input logic [2:0] req, input int from, input int excl, input int n);
    int c;
    for (int j = 1; j <= n; j++) begin
      c = (from + j) % n;
      if (req[c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic model_reset(input int k);
    m_busy[k] = 1'b0;
    m_g[k]    = 0;
    m_last[k] = nrd_of(k) - 1;
    m_data[k] = init_of(k);
  endtask

  task automatic predict(input int k);
    e_dv[k]  = m_busy[k] ? 3'(1 << m_g[k]) : 3'b000;
    e_dir[k] = !m_busy[k] || i_dr[k][m_g[k]];
    e_rr[k]  = (m_busy[k] && i_dr[k][m_g[k]]) ? e_dv[k] : 3'b000;
  endtask

  task automatic model_step(input int k);
    int w;
    if (i_dv[k] && e_dir[k]) m_data[k] = i_dd[k];
    if (!m_busy[k]) begin
      w = rr_next(rv[k], m_last[k], -1, nrd_of(k));
      if (w >= 0) begin
        m_busy[k] = 1'b1;
        m_g[k]    = w;
        m_last[k] = w;
      end
    end else if (i_dr[k][m_g[k]]) begin
      w = rr_next(rv[k], m_g[k], m_g[k], nrd_of(k));
      if (w >= 0) begin
        m_g[k]    = w;
        m_last[k] = w;
      end else begin
        m_busy[k] = 1'b0;
      end
    end
  endtask

  // One clock: compare both instances to the model, then advance the model at the edge.
  task automatic tick();
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!rst) model_reset(k);
      predict(k);
      check($sformatf("k%0d_dout_valid", k), W'(o_dv[k]), W'(e_dv[k]));
      check($sformatf("k%0d_rd_ready", k), W'(o_rr[k]), W'(e_rr[k]));
      check($sformatf("k%0d_din_ready", k), W'(o_dir[k]), W'(e_dir[k]));
      if (m_busy[k]) check($sformatf("k%0d_dout_data", k), o_dd[k][m_g[k]], m_data[k]);
      hs_rd[k]  = rv[k] & e_rr[k];
      wr_acc[k] = i_dv[k] && e_dir[k] && rst;
    end
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 2; k++) model_step(k);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rv[k]     = '0;
      i_dr[k]   = '0;
      i_dv[k]   = 1'b0;
      i_dd[k]   = '0;
      hs_rd[k]  = '0;
      wr_acc[k] = 1'b0;
      model_reset(k);
    end
    @(negedge clk);

    // Reset: write dropped, din ready high; reader 1 requests across release.
    rv[0] = 3'b010; i_dv[0] = 1'b1; i_dd[0] = 16'h0055; i_dr[0] = 3'b010;
    tick();
    check("rst_din_ready", W'(o_dir[0]), W'(1'b1));
    check("rst_dout_valid", W'(o_dv[0]), W'(3'b000));
    tick();
    rst = 1'b1; i_dv[0] = 1'b0;
    tick();
    check("first_grant_valid", W'(o_dv[0]), W'(3'b010));
    check("first_grant_data", o_dd[0][1], 16'd5);
    check("first_grant_rd_ready", W'(o_rr[0]), W'(3'b010));
    tick();
    rv[0] = '0;
    tick();

    // Both readers continuously requesting: 0,1,0,1,... with no bubbles.
    rv[0] = 3'b011; i_dr[0] = 3'b011;
    for (int t = 0; t < 6; t++) begin
      tick();
      check($sformatf("alt_grant_%0d", t), W'(o_dv[0]), W'((t % 2 == 0) ? 3'b001 : 3'b010));
    end
    rv[0] = 3'b010;
    tick();
    rv[0] = '0;
    tick();

    // Write stalled behind a pending read; reader sees old value, next grant sees 7.
    rv[0] = 3'b001; i_dr[0] = 3'b000;
    tick();
    i_dv[0] = 1'b1; i_dd[0] = 16'd7;
    for (int t = 0; t < 3; t++) begin
      #1;
      check($sformatf("stall_din_ready_%0d", t), W'(o_dir[0]), W'(1'b0));
      check($sformatf("stall_data_%0d", t), o_dd[0][0], 16'd5);
      tick();
    end
    i_dr[0] = 3'b001;
    #1;
    check("hs_din_ready", W'(o_dir[0]), W'(1'b1));
    check("hs_old_data", o_dd[0][0], 16'd5);
    tick();
    i_dv[0] = 1'b0;
    tick();
    check("post_write_valid", W'(o_dv[0]), W'(3'b001));
    check("post_write_data", o_dd[0][0], 16'd7);
    tick();
    rv[0] = '0;
    tick();

    // Write accepted in IDLE in the same cycle a grant is chosen.
    i_dv[0] = 1'b1; i_dd[0] = 16'd9; rv[0] = 3'b001;
    #1;
    check("idle_din_ready", W'(o_dir[0]), W'(1'b1));
    tick();
    i_dv[0] = 1'b0;
    check("same_cycle_write_data", o_dd[0][0], 16'd9);
    tick();
    rv[0] = '0;
    tick();

    // Reset during a grant drops it and restores INIT.
    i_dv[0] = 1'b1; i_dd[0] = 16'd3;
    tick();
    i_dv[0] = 1'b0; rv[0] = 3'b001; i_dr[0] = 3'b000;
    tick();
    #1;
    check("pre_reset_data", o_dd[0][0], 16'd3);
    rst = 1'b0;
    #1;
    check("mid_reset_valid", W'(o_dv[0]), W'(3'b000));
    check("mid_reset_din_ready", W'(o_dir[0]), W'(1'b1));
    tick();
    rst = 1'b1; i_dr[0] = 3'b001;
    tick();
    check("after_reset_valid", W'(o_dv[0]), W'(3'b001));
    check("after_reset_data", o_dd[0][0], 16'd5);
    tick();
    rv[0] = '0;
    tick();

    // NRD=3, readers 0 and 2 continuous, reader 1 idle: 0,2,0,2,...
    rv[1] = 3'b101; i_dr[1] = 3'b111;
    for (int t = 0; t < 6; t++) begin
      tick();
      check($sformatf("nrd3_grant_%0d", t), W'(o_dv[1]), W'((t % 2 == 0) ? 3'b001 : 3'b100));
      check($sformatf("nrd3_data_%0d", t), o_dd[1][(t % 2 == 0) ? 0 : 2], 16'h00A0);
    end
    rv[1] = 3'b100;
    tick();
    rv[1] = '0;
    tick();

    // Randomized traffic that respects hold-until-ready on requests and writes.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < nrd_of(k); i++) begin
          if (!(rv[k][i] && !hs_rd[k][i])) rv[k][i] = ($urandom_range(0, 3) != 0);
        end
        i_dr[k] = 3'($urandom) & ((k == 0) ? 3'b011 : 3'b111);
        if (!(i_dv[k] && !wr_acc[k])) begin
          i_dv[k] = ($urandom_range(0, 1) == 1);
          i_dd[k] = 16'($urandom);
        end
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
